// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register slave and its PWM-side consumers.
//   - Register address map for the five PWM control registers.
//   - Frame geometry (16-bit frames, MSB first) and bit-counter sizing.
//   - FSM state encoding, exposed both as plain localparams (for benches that
//     only want the numeric encoding) and as the typed enum used by the RTL.
package spi_reg_pkg;

    // Register address map.
    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    // Frame layout: [15] = R/W (1 = write), [14:8] = address, [7:0] = data.
    localparam int unsigned FRAME_BITS = 16;

    // Bit counter is wide enough to hold one past a full frame, so frames that
    // are too long stay distinguishable from exact-length ones.
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned CNT_SAT = FRAME_BITS + 1;

    // FSM state encoding.
    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_SHIFT  = 2'd1;
    localparam logic [1:0] STATE_COMMIT = 2'd2;

    typedef enum logic [1:0] {
        StIdle   = STATE_IDLE,
        StShift  = STATE_SHIFT,
        StCommit = STATE_COMMIT
    } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by a history flop, producing single-cycle
// rise and fall pulses on the synchronized level.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset; all flops load RESET_VAL
//   din    in   asynchronous input pin
//   rise   out  one-cycle pulse when the synchronized level goes 0 -> 1
//   fall   out  one-cycle pulse when the synchronized level goes 1 -> 0
//
// Resetting to the pin's idle level keeps reset release from producing a
// spurious edge while the pin is idle.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 write-only slave that turns 16-bit frames into the control
// registers feeding the PWM stage. All SPI pins are asynchronous and are
// sampled on clk; clk must run at least 4x the SPI clock.
//
// Ports:
//   clk              in   system clock (only clock in this block)
//   rst_n            in   synchronous active-low reset
//   sclk             in   SPI clock, asynchronous
//   copi             in   SPI data in, asynchronous
//   ncs              in   SPI chip select, active-low, asynchronous
//   en_reg_out_7_0   out  register 0x00
//   en_reg_out_15_8  out  register 0x01
//   en_reg_pwm_7_0   out  register 0x02
//   en_reg_pwm_15_8  out  register 0x03
//   pwm_duty_cycle   out  register 0x04
//   wr_done          out  one-cycle pulse when a register is written
//   frame_err        out  one-cycle pulse when a frame is discarded
//
// Frame, MSB first: [15] = R/W (1 = write), [14:8] = address, [7:0] = data.
// A write lands SYNC_STAGES+2 clk edges after the ncs pin rises.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_REGS    = 5,  // must be >= 5 to back all outputs
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              wr_done,
    output logic              frame_err
);

    localparam int unsigned FW = 1 + ADDR_W + DATA_W;

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic sclk_rise;
    logic ncs_rise;
    logic ncs_fall;
    logic unused_sclk_fall;  // mode 0 shifts on rising edges only

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .rise  (sclk_rise),
        .fall  (unused_sclk_fall)
    );

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_ncs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ncs),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    // copi only needs a level, taken at the same depth as the sclk level so
    // the bit sampled on a detected rise is the one the master presented.
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic                   copi_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            copi_sync_q <= '0;
        end else begin
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
        end
    end

    assign copi_sync = copi_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame decode
    // ------------------------------------------------------------------
    spi_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [FW-1:0]     shift_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic              frame_rw;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic              addr_in_range;
    logic              len_ok;

    assign frame_rw      = shift_q[FW-1];
    assign frame_addr    = shift_q[DATA_W +: ADDR_W];
    assign frame_data    = shift_q[DATA_W-1:0];
    assign addr_in_range = (32'(frame_addr) < NUM_REGS);
    assign len_ok        = (cnt_q == CNT_W'(FRAME_BITS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            wr_done   <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_done   <= 1'b0;
            frame_err <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (ncs_fall) begin
                        state_q <= StShift;
                        cnt_q   <= '0;
                    end
                end

                StShift: begin
                    // Deselect takes priority over a coincident sclk rise.
                    if (ncs_rise) begin
                        state_q <= StCommit;
                    end else if (sclk_rise) begin
                        shift_q <= {shift_q[FW-2:0], copi_sync};
                        if (cnt_q != CNT_W'(CNT_SAT)) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                StCommit: begin
                    // A new select arriving here is dropped; the master is
                    // required to hold ncs high long enough to avoid that.
                    state_q <= StIdle;
                    if (!len_ok) begin
                        frame_err <= 1'b1;
                    end else if (frame_rw) begin
                        if (addr_in_range) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (frame_addr == ADDR_W'(i)) begin
                                    regs_q[i] <= frame_data;
                                end
                            end
                            wr_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    // Correct-length read frames are accepted silently.
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Register-to-output map follows the ADDR_* constants in the package.
    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

endmodule
